// File: rtl/shift64_seq.sv
// shift64_seq: sequences a 2*DW-bit shift over an external DW-bit combinational barrel shifter.
// Rev 1.0
`default_nettype none

module shift64_seq #(
  parameter int DW = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DW-1:0]         in_data,
  input  logic [$clog2(2*DW)-1:0] in_shift,
  input  logic                    in_right,
  input  logic                    in_arith,
  output logic [DW-1:0]           sh_data,
  output logic [$clog2(DW)-1:0]   sh_shift,
  output logic                    sh_right,
  output logic                    sh_arith,
  input  logic [DW-1:0]           sh_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DW-1:0]         out_data
);

  localparam int AW = $clog2(2*DW);
  localparam int SW = $clog2(DW);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0]   res_q, res_d, tmp_q, tmp_d;
  logic [AW-1:0]   s_q, s_d;
  logic            right_q, right_d, arith_q, arith_d;
  logic [2*DW-1:0] out_data_q, out_data_d;

  logic            big;
  logic [SW-1:0]   amt;
  logic [SW-1:0]   amt_c;

  // big: whole-word move (s >= DW); amt_c is DW - s for the cross-half pass
  assign big   = s_q[AW-1];
  assign amt   = s_q[SW-1:0];
  assign amt_c = -amt;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;

  always_comb begin
    sh_data  = '0;
    sh_shift = '0;
    sh_right = 1'b0;
    sh_arith = 1'b0;
    case (state_q)
      P0: begin
        sh_data  = right_q ? hi_q : lo_q;
        sh_shift = amt;
        sh_right = right_q;
        sh_arith = right_q & arith_q;
      end
      P1: begin
        if (big) begin
          // sign fill for the upper half of an arithmetic right shift
          sh_data  = hi_q;
          sh_shift = {SW{1'b1}};
          sh_right = 1'b1;
          sh_arith = 1'b1;
        end else begin
          sh_data  = right_q ? lo_q : hi_q;
          sh_shift = amt;
          sh_right = right_q;
        end
      end
      P2: begin
        sh_data  = right_q ? hi_q : lo_q;
        sh_shift = amt_c;
        sh_right = ~right_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    res_d      = res_q;
    tmp_d      = tmp_q;
    s_d        = s_q;
    right_d    = right_q;
    arith_d    = arith_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          hi_d    = in_data[2*DW-1:DW];
          lo_d    = in_data[DW-1:0];
          s_d     = in_shift;
          right_d = in_right;
          arith_d = in_arith & in_right;
          if (in_shift == '0) begin
            out_data_d = in_data;
            state_d    = DONE;
          end else begin
            state_d = P0;
          end
        end
      end
      P0: begin
        if (big && !(right_q && arith_q)) begin
          out_data_d = right_q ? {{DW{1'b0}}, sh_result} : {sh_result, {DW{1'b0}}};
          state_d    = DONE;
        end else begin
          res_d   = sh_result;
          state_d = P1;
        end
      end
      P1: begin
        if (big) begin
          out_data_d = {sh_result, res_q};
          state_d    = DONE;
        end else begin
          tmp_d   = sh_result;
          state_d = P2;
        end
      end
      P2: begin
        out_data_d = right_q ? {res_q, tmp_q | sh_result} : {tmp_q | sh_result, res_q};
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      res_q      <= '0;
      tmp_q      <= '0;
      s_q        <= '0;
      right_q    <= 1'b0;
      arith_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      res_q      <= res_d;
      tmp_q      <= tmp_d;
      s_q        <= s_d;
      right_q    <= right_d;
      arith_q    <= arith_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

`default_nettype wire
